// File: rtl/ram_slave_pkg.sv
// Shared types and widths for the RAM-window bus responder.
package ram_slave_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} readState_e;

  // Byte-lane merge used for strobed writes and for same-edge forwarding.
  function automatic logic [AXI_DATA_W-1:0] merge_bytes(
    input logic [AXI_DATA_W-1:0] old_word,
    input logic [AXI_DATA_W-1:0] new_word,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < AXI_STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_slave_array.sv
// Word storage with one byte-enabled write port and one registered read port;
// a read sampled on the same edge as a write to that word returns the merged new word.
module ram_slave_array
  import ram_slave_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_idx,
  input  logic [AXI_DATA_W-1:0] wr_data,
  input  logic [AXI_STRB_W-1:0] wr_strb,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_idx,
  output logic [AXI_DATA_W-1:0] rd_data
);

  logic [AXI_DATA_W-1:0] mem [DEPTH_WORDS];
  logic [AXI_DATA_W-1:0] rd_data_d, rd_data_q;

  // NOTE: the storage array has no reset branch so it maps onto block RAM;
  // its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < AXI_STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (wr_en && (wr_idx == rd_idx)) begin
        rd_data_d = merge_bytes(mem[rd_idx], wr_data, wr_strb);
      end else begin
        rd_data_d = mem[rd_idx];
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_axi_slave.sv
// Word-addressed RAM responder: pairs independent write address/data beats and
// returns reads after READ_LATENCY cycles. Define RAM_SLAVE_WSTRB_EN for byte strobes.
module ram_axi_slave
  import ram_slave_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  resetActiveLow,
  input  logic [AXI_ADDR_W-1:0] axiWriteAddress,
  input  logic                  axiWriteValid,
  output logic                  axiWriteReady,
  input  logic [AXI_DATA_W-1:0] axiWriteData,
`ifdef RAM_SLAVE_WSTRB_EN
  input  logic [AXI_STRB_W-1:0] axiWriteStrobe,
`endif
  input  logic                  axiWriteValidData,
  output logic                  axiWriteReadyData,
  input  logic [AXI_ADDR_W-1:0] axiReadAddress,
  input  logic                  axiReadValid,
  output logic                  axiReadReady,
  output logic [AXI_DATA_W-1:0] axiReadData,
  output logic                  axiReadValidData,
  input  logic                  axiReadReadyData
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_INIT = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  logic [AXI_STRB_W-1:0] strb_in;
`ifdef RAM_SLAVE_WSTRB_EN
  assign strb_in = axiWriteStrobe;
`else
  assign strb_in = '1;
`endif

  logic [AW-1:0] aw_idx, ar_idx;
  assign aw_idx = axiWriteAddress[AW+1:2];
  assign ar_idx = axiReadAddress[AW+1:2];

  // The window aliases: byte offset and bits above the index are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axiWriteAddress[AXI_ADDR_W-1:AW+2], axiWriteAddress[1:0],
                              axiReadAddress[AXI_ADDR_W-1:AW+2], axiReadAddress[1:0]};

  // ---------------- write pairing ----------------
  logic                  addr_held_d, addr_held_q;
  logic                  data_held_d, data_held_q;
  logic [AW-1:0]         wr_idx_d, wr_idx_q;
  logic [AXI_DATA_W-1:0] wr_data_d, wr_data_q;
  logic [AXI_STRB_W-1:0] wr_strb_d, wr_strb_q;
  logic                  commit;

  assign commit            = addr_held_q && data_held_q;
  assign axiWriteReady     = !addr_held_q;
  assign axiWriteReadyData = !data_held_q;

  always_comb begin
    addr_held_d = addr_held_q;
    data_held_d = data_held_q;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    if (commit) begin
      addr_held_d = 1'b0;
      data_held_d = 1'b0;
    end
    if (axiWriteValid && !addr_held_q) begin
      addr_held_d = 1'b1;
      wr_idx_d    = aw_idx;
    end
    if (axiWriteValidData && !data_held_q) begin
      data_held_d = 1'b1;
      wr_data_d   = axiWriteData;
      wr_strb_d   = strb_in;
    end
  end

  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      addr_held_q <= 1'b0;
      data_held_q <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
    end else begin
      addr_held_q <= addr_held_d;
      data_held_q <= data_held_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
    end
  end

  // ---------------- read FSM ----------------
  readState_e    state_d, state_q;
  logic [1:0]    cnt_d, cnt_q;
  logic [AW-1:0] rd_idx_d, rd_idx_q;
  logic          sample;
  logic [AW-1:0] sample_idx;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    rd_idx_d         = rd_idx_q;
    sample           = 1'b0;
    sample_idx       = rd_idx_q;
    axiReadReady     = 1'b0;
    axiReadValidData = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        axiReadReady = 1'b1;
        if (axiReadValid) begin
          rd_idx_d = ar_idx;
          if (READ_LATENCY == 1) begin
            // Single-cycle latency samples straight from the incoming address.
            state_d    = RD_RESP;
            sample     = 1'b1;
            sample_idx = ar_idx;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RD_RESP;
          sample  = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RD_RESP: begin
        axiReadValidData = 1'b1;
        if (axiReadReadyData) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      state_q  <= RD_IDLE;
      cnt_q    <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  ram_slave_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clock),
    .rst_n   (resetActiveLow),
    .wr_en   (commit),
    .wr_idx  (wr_idx_q),
    .wr_data (wr_data_q),
    .wr_strb (wr_strb_q),
    .rd_en   (sample),
    .rd_idx  (sample_idx),
    .rd_data (axiReadData)
  );

endmodule

// File: tb/tb_ram_axi_slave.sv
// Directed bench for ram_axi_slave (READ_LATENCY = 3) with a read-response scoreboard.
module tb_ram_axi_slave;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0, r_data;
  logic        aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0, r_ready = 1'b0;
  logic        aw_ready, w_ready, ar_ready, r_valid;
  logic [3:0]  w_strb = 4'hF;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_axi_slave #(
    .DEPTH_WORDS  (1024),
    .READ_LATENCY (RL)
  ) dut (
    .clock             (clk),
    .resetActiveLow    (rst_n),
    .axiWriteAddress   (aw_addr),
    .axiWriteValid     (aw_valid),
    .axiWriteReady     (aw_ready),
    .axiWriteData      (w_data),
`ifdef RAM_SLAVE_WSTRB_EN
    .axiWriteStrobe    (w_strb),
`endif
    .axiWriteValidData (w_valid),
    .axiWriteReadyData (w_ready),
    .axiReadAddress    (ar_addr),
    .axiReadValid      (ar_valid),
    .axiReadReady      (ar_ready),
    .axiReadData       (r_data),
    .axiReadValidData  (r_valid),
    .axiReadReadyData  (r_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic a_done, d_done, a_hs, d_hs;
    int n;
    a_done = 1'b0; d_done = 1'b0; n = 0;
    aw_addr = a; w_data = d; w_strb = s; aw_valid = 1'b1; w_valid = 1'b1;
    while (!(a_done && d_done) && n < 20) begin
      a_hs = aw_valid && aw_ready;
      d_hs = w_valid && w_ready;
      @(negedge clk);
      if (a_hs) begin a_done = 1'b1; aw_valid = 1'b0; end
      if (d_hs) begin d_done = 1'b1; w_valid = 1'b0; end
      n++;
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    check("wr_accept", 32'(a_done && d_done), 32'd1);
  endtask

  task automatic read_issue(input logic [31:0] a, input logic [31:0] exp);
    int n;
    n = 0;
    ar_addr = a; ar_valid = 1'b1;
    while (!ar_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_accept", 32'(ar_ready), 32'd1);
    exp_q.push_back(exp);
    lat_q.push_back(cyc + RL);
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    logic [31:0] e;
    int l;
    n = 0;
    while (!r_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("r_valid_seen", 32'(r_valid), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      check("r_data", r_data, e);
      check("r_latency", 32'(cyc), 32'(l));
    end else begin
      check("sb_nonempty", 32'(exp_q.size()), 32'd1);
    end
  endtask

  task automatic read_response();
    wait_valid();
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_aw_ready", 32'(aw_ready), 32'd1);
    check("rst_w_ready", 32'(w_ready), 32'd1);
    check("rst_ar_ready", 32'(ar_ready), 32'd1);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_r_data", r_data, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Address and data in the same cycle, then read back
    do_write(32'h2000_0010, 32'hDEAD_BEEF, 4'hF);
    read_issue(32'h2000_0010, 32'hDEAD_BEEF);
    read_response();

    // Data three cycles ahead of its address
    w_data = 32'h1234_5678; w_strb = 4'hF; w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    check("wready_held_0", 32'(w_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("wready_held_2", 32'(w_ready), 32'd0);
    aw_addr = 32'h2000_0020; aw_valid = 1'b1;
    check("awready_late", 32'(aw_ready), 32'd1);
    @(negedge clk);
    aw_valid = 1'b0;
    check("commit_w_ready", 32'(w_ready), 32'd0);
    check("commit_aw_ready", 32'(aw_ready), 32'd0);
    @(negedge clk);
    check("post_commit_w_ready", 32'(w_ready), 32'd1);
    check("post_commit_aw_ready", 32'(aw_ready), 32'd1);
    read_issue(32'h2000_0020, 32'h1234_5678);
    read_response();

    // Backpressure: response held, second read address refused
    read_issue(32'h2000_0010, 32'hDEAD_BEEF);
    wait_valid();
    ar_addr = 32'h2000_0020; ar_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_r_valid", 32'(r_valid), 32'd1);
      check("bp_r_data", r_data, 32'hDEAD_BEEF);
      check("bp_ar_ready", 32'(ar_ready), 32'd0);
      @(negedge clk);
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check("bp_released_valid", 32'(r_valid), 32'd0);
    check("bp_next_ar_ready", 32'(ar_ready), 32'd1);
    exp_q.push_back(32'h1234_5678);
    lat_q.push_back(cyc + RL);
    @(negedge clk);
    ar_valid = 1'b0;
    read_response();

    // Same-edge commit and sample: read handshake, then write one cycle later,
    // so the commit lands exactly RL-1 edges after the read handshake.
    ar_addr = 32'h2000_0030; ar_valid = 1'b1;
    check("hz_ar_ready", 32'(ar_ready), 32'd1);
    exp_q.push_back(32'hCAFE_F00D);
    lat_q.push_back(cyc + RL);
    @(negedge clk);
    ar_valid = 1'b0;
    aw_addr = 32'h2000_0030; w_data = 32'hCAFE_F00D; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    check("hz_addr_held", 32'(aw_ready), 32'd0);
    @(negedge clk);
    read_response();
    read_issue(32'h2000_0030, 32'hCAFE_F00D);
    read_response();

    // Aliased address with nonzero byte offset
    read_issue(32'h3000_1013, 32'hDEAD_BEEF);
    read_response();

    // Reset during RD_WAIT with a lone write address held
    aw_addr = 32'h2000_0010; aw_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0;
    check("rst_pre_addr_held", 32'(aw_ready), 32'd0);
    ar_addr = 32'h2000_0010; ar_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0;
    check("rst_pre_in_wait", 32'(ar_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_r_valid", 32'(r_valid), 32'd0);
    check("rst_mid_ar_ready", 32'(ar_ready), 32'd1);
    check("rst_mid_aw_ready", 32'(aw_ready), 32'd1);
    check("rst_mid_w_ready", 32'(w_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (r_valid) seen = 1'b1;
    end
    check("rst_no_response", 32'(seen), 32'd0);

    // The dropped address must not pair with fresh data
    w_data = 32'h5555_5555; w_strb = 4'hF; w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    check("rst_addr_dropped", 32'(aw_ready), 32'd1);
    check("rst_data_held", 32'(w_ready), 32'd0);
    aw_addr = 32'h2000_0040; aw_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0;
    @(negedge clk);
    read_issue(32'h2000_0010, 32'hDEAD_BEEF);
    read_response();
    read_issue(32'h2000_0040, 32'h5555_5555);
    read_response();

`ifdef RAM_SLAVE_WSTRB_EN
    // Byte-strobed partial write
    do_write(32'h2000_0050, 32'h1122_3344, 4'hF);
    do_write(32'h2000_0050, 32'hAABB_CCDD, 4'b0011);
    read_issue(32'h2000_0050, 32'h1122_CCDD);
    read_response();
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
